// File: rtl/data_mem_io_if.sv
// MEM-stage load/store bus between the EX/MEM register and the data memory / I/O block.
// MemRd and MemWr are qualifiers with no back-pressure: MemRdData is valid in the same cycle as MemRd, and a store commits on the rising edge that closes a MemWr cycle.
interface data_mem_io_if;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] MemRdData;

  modport master (output MemRd, output MemWr, output Addr, output WrData, input MemRdData);
  modport slave  (input MemRd, input MemWr, input Addr, input WrData, output MemRdData);
endinterface

// File: rtl/data_mem_io.sv
// MEM-stage word-addressed data RAM plus memory-mapped interval timer, LED and 7-segment registers.
// Define SYSTICK_EN to add a read-only free-running cycle counter at IO_BASE+0x14.
module data_mem_io #(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] IO_BASE   = 32'h4000_0000
) (
  input  logic         clk,
  input  logic         rst,
  data_mem_io_if.slave bus,
  output logic [7:0]   leds,
  output logic [11:0]  digi,
  output logic         irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0] mem [RAM_WORDS];

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  leds_q, leds_d;
  logic [11:0] digi_q, digi_d;

  logic [31:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          ram_hit, sel_th, sel_tl, sel_tcon, sel_leds, sel_digi;
  logic [31:0]   rd_data;

  // Byte offset bits are dropped so every access lands on a whole word.
  assign word_addr = bus.Addr & 32'hFFFF_FFFC;
  assign ram_idx   = word_addr[AW+1:2];
  assign ram_hit   = word_addr < RAM_BYTES;
  assign sel_th    = word_addr == IO_BASE;
  assign sel_tl    = word_addr == IO_BASE + 32'h04;
  assign sel_tcon  = word_addr == IO_BASE + 32'h08;
  assign sel_leds  = word_addr == IO_BASE + 32'h0C;
  assign sel_digi  = word_addr == IO_BASE + 32'h10;

`ifdef SYSTICK_EN
  logic [31:0] systick_q;
  logic        sel_systick;

  assign sel_systick = word_addr == IO_BASE + 32'h14;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) systick_q <= '0;
    else      systick_q <= systick_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (bus.MemWr && ram_hit) mem[ram_idx] <= bus.WrData;
  end

  always_comb begin
    rd_data = '0;
    if (bus.MemRd) begin
      if (ram_hit)       rd_data = mem[ram_idx];
      else if (sel_th)   rd_data = th_q;
      else if (sel_tl)   rd_data = tl_q;
      else if (sel_tcon) rd_data = {29'd0, tcon_q};
      else if (sel_leds) rd_data = {24'd0, leds_q};
      else if (sel_digi) rd_data = {20'd0, digi_q};
`ifdef SYSTICK_EN
      else if (sel_systick) rd_data = systick_q;
`endif
    end
  end

  assign bus.MemRdData = rd_data;

  // Timer update first, CPU writes last so a store always overrides the count.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    leds_d = leds_q;
    digi_d = digi_q;
    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d      = th_q;
        tcon_d[2] = tcon_q[2] | tcon_q[1];
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (bus.MemWr) begin
      if (sel_th)   th_d   = bus.WrData;
      if (sel_tl)   tl_d   = bus.WrData;
      if (sel_tcon) tcon_d = bus.WrData[2:0];
      if (sel_leds) leds_d = bus.WrData[7:0];
      if (sel_digi) digi_d = bus.WrData[11:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      leds_q <= '0;
      digi_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      leds_q <= leds_d;
      digi_q <= digi_d;
    end
  end

  assign leds = leds_q;
  assign digi = digi_q;
  assign irq  = tcon_q[2] & tcon_q[1];

endmodule

// File: tb/tb_data_mem_io.sv
// Directed table-driven bench for data_mem_io: RAM, timer reload/priority, peripherals, async reset.
module tb_data_mem_io;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk;
  logic        rst;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        irq;
  int          checks;
  int          errors;

  data_mem_io_if bus ();

  data_mem_io #(.RAM_WORDS(256), .IO_BASE(B)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .leds (leds),
    .digi (digi),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
    logic [11:0] exp_digi;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];
  vec_t post[$];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] exp_rd, logic [7:0] exp_leds, logic [11:0] exp_digi,
                              logic exp_irq);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_leds = exp_leds; v.exp_digi = exp_digi; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    @(negedge clk);
    bus.MemRd  = v.rd;
    bus.MemWr  = v.wr;
    bus.Addr   = v.addr;
    bus.WrData = v.wdata;
    #1;
    chk({tag, "_rd"},   idx, bus.MemRdData, v.exp_rd);
    chk({tag, "_leds"}, idx, {24'd0, leds}, {24'd0, v.exp_leds});
    chk({tag, "_digi"}, idx, {20'd0, digi}, {20'd0, v.exp_digi});
    chk({tag, "_irq"},  idx, {31'd0, irq},  {31'd0, v.exp_irq});
  endtask

  initial begin
    logic [31:0] st_a, st_b;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.MemRd = 1'b0; bus.MemWr = 1'b0; bus.Addr = '0; bus.WrData = '0;

    // Reset values
    vecs.push_back(mk(1, 0, B + 32'h00, 0, 32'h0, 8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0, 32'h0, 8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h08, 0, 32'h0, 8'h00, 12'h000, 0));
    // RAM
    vecs.push_back(mk(0, 1, 32'h10,  32'hDEAD_BEEF, 32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, 32'h10,  0,             32'hDEAD_BEEF, 8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, 32'h13,  0,             32'hDEAD_BEEF, 8'h00, 12'h000, 0));
    vecs.push_back(mk(0, 0, 32'h10,  0,             32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(0, 1, 32'h3FC, 32'h1234_5678, 32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, 32'h3FC, 0,             32'h1234_5678, 8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, 32'h400, 0,             32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 1, 32'h10,  32'hCAFE_F00D, 32'hDEAD_BEEF, 8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, 32'h10,  0,             32'hCAFE_F00D, 8'h00, 12'h000, 0));
    // Timer reload and interrupt
    vecs.push_back(mk(0, 1, B + 32'h00, 32'hFFFF_FFF0, 32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(0, 1, B + 32'h04, 32'hFFFF_FFFE, 32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(0, 1, B + 32'h08, 32'h3,         32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'hFFFF_FFFE, 8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'hFFFF_FFFF, 8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'hFFFF_FFF0, 8'h00, 12'h000, 1));
    vecs.push_back(mk(1, 0, B + 32'h08, 0,             32'h7,         8'h00, 12'h000, 1));
    vecs.push_back(mk(0, 1, B + 32'h08, 32'h3,         32'h0,         8'h00, 12'h000, 1));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'hFFFF_FFF3, 8'h00, 12'h000, 0));
    // TL write beats increment
    vecs.push_back(mk(1, 1, B + 32'h04, 32'h5,         32'hFFFF_FFF4, 8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'h5,         8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'h6,         8'h00, 12'h000, 0));
    // Disable freezes TL
    vecs.push_back(mk(0, 1, B + 32'h08, 32'h0,         32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'h8,         8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'h8,         8'h00, 12'h000, 0));
    // TCON write on the overflow edge wins, bit 2 included
    vecs.push_back(mk(0, 1, B + 32'h00, 32'h100,       32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(0, 1, B + 32'h04, 32'hFFFF_FFFF, 32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(0, 1, B + 32'h08, 32'h3,         32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(0, 1, B + 32'h08, 32'h2,         32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h08, 0,             32'h2,         8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'h100,       8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'h100,       8'h00, 12'h000, 0));
    // TH write on the overflow edge: reload still uses old TH
    vecs.push_back(mk(0, 1, B + 32'h04, 32'hFFFF_FFFF, 32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(0, 1, B + 32'h08, 32'h3,         32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(0, 1, B + 32'h00, 32'h200,       32'h0,         8'h00, 12'h000, 0));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'h100,       8'h00, 12'h000, 1));
    vecs.push_back(mk(1, 0, B + 32'h04, 0,             32'h101,       8'h00, 12'h000, 1));
    vecs.push_back(mk(1, 0, B + 32'h00, 0,             32'h200,       8'h00, 12'h000, 1));
    // Peripherals and unmapped window
    vecs.push_back(mk(0, 1, B + 32'h0C, 32'h5A,        32'h0,         8'h00, 12'h000, 1));
    vecs.push_back(mk(0, 1, B + 32'h10, 32'h83F,       32'h0,         8'h5A, 12'h000, 1));
    vecs.push_back(mk(1, 0, B + 32'h0C, 0,             32'h5A,        8'h5A, 12'h83F, 1));
    vecs.push_back(mk(1, 0, B + 32'h10, 0,             32'h83F,       8'h5A, 12'h83F, 1));
    vecs.push_back(mk(0, 1, B + 32'h20, 32'hFFFF_FFFF, 32'h0,         8'h5A, 12'h83F, 1));
    vecs.push_back(mk(1, 0, B + 32'h20, 0,             32'h0,         8'h5A, 12'h83F, 1));
    vecs.push_back(mk(1, 0, B + 32'h00, 0,             32'h200,       8'h5A, 12'h83F, 1));
    vecs.push_back(mk(0, 1, B + 32'h0C, 32'h1234_56A5, 32'h0,         8'h5A, 12'h83F, 1));
    vecs.push_back(mk(1, 0, B + 32'h0C, 0,             32'hA5,        8'hA5, 12'h83F, 1));

    // After the mid-count reset: timer idle, RAM intact
    post.push_back(mk(1, 0, B + 32'h04, 0, 32'h0,         8'h00, 12'h000, 0));
    post.push_back(mk(1, 0, B + 32'h04, 0, 32'h0,         8'h00, 12'h000, 0));
    post.push_back(mk(1, 0, 32'h10,     0, 32'hCAFE_F00D, 8'h00, 12'h000, 0));
    post.push_back(mk(1, 0, 32'h3FC,    0, 32'h1234_5678, 8'h00, 12'h000, 0));
    post.push_back(mk(1, 0, B + 32'h08, 0, 32'h0,         8'h00, 12'h000, 0));

    repeat (3) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_vec("vec", i, vecs[i]);

    // Asynchronous reset between edges while the timer is counting
    @(negedge clk);
    bus.MemWr = 1'b0;
    bus.MemRd = 1'b1;
    bus.Addr  = B + 32'h08;
    #1;
    chk("pre_rst_tcon", 0, bus.MemRdData, 32'h7);
    chk("pre_rst_irq",  0, {31'd0, irq}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_tcon", 0, bus.MemRdData, 32'h0);
    chk("rst_irq",  0, {31'd0, irq},  32'h0);
    chk("rst_leds", 0, {24'd0, leds}, 32'h0);
    chk("rst_digi", 0, {20'd0, digi}, 32'h0);
    bus.Addr = B + 32'h04;
    #1;
    chk("rst_tl", 0, bus.MemRdData, 32'h0);
    bus.Addr = B + 32'h00;
    #1;
    chk("rst_th", 0, bus.MemRdData, 32'h0);
    rst = 1'b1;

    foreach (post[i]) run_vec("post", i, post[i]);

    @(negedge clk);
    bus.MemRd = 1'b1;
    bus.MemWr = 1'b0;
    bus.Addr  = B + 32'h14;
    #1;
    st_a = bus.MemRdData;
`ifdef SYSTICK_EN
    repeat (7) @(negedge clk);
    #1;
    st_b = bus.MemRdData;
    chk("systick_delta", 0, st_b - st_a, 32'd7);
`else
    st_b = 32'h0;
    chk("systick_unmapped", 0, st_a, st_b);
`endif

    @(negedge clk);
    bus.MemRd = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
- MEM-stage data memory and memory-mapped I/O block. It sits between the EX/MEM register and the MEM/WB register.
- Takes the EX/MEM ALU result as the address, with the EX/MEM store data and control signals.
- Returns a combinational read word that MEM/WB latches on the same edge.
- Contains the word-addressed data RAM, an interval timer with interrupt, and LED / 7-segment output registers.

Parameters:
- RAM_WORDS, 256, data RAM depth in 32-bit words; power of two.
- IO_BASE, 32'h4000_0000, base address of the peripheral register window.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- MemRd  input  1  load enable from EX/MEM.
- MemWr  input  1  store enable from EX/MEM.
- Addr  input  32  byte address (EX/MEM ALU result).
- WrData  input  32  store data.
- MemRdData  output  32  read data to MEM/WB; combinational.
- leds  output  8  LED register.
- digi  output  12  7-segment register: [11:8] anode select, [7:0] segments.
- irq  output  1  timer interrupt request; equals TCON[2] & TCON[1].

Behaviour:
- Addr[1:0] is ignored; all accesses are whole words.
- Address map:
  - RAM: Addr < RAM_WORDS*4, index Addr[log2(RAM_WORDS)+1:2].
  - TH: IO_BASE+0x00.
  - TL: IO_BASE+0x04.
  - TCON: IO_BASE+0x08, bits [2:0] only.
  - leds: IO_BASE+0x0C.
  - digi: IO_BASE+0x10.
  - SysTick: IO_BASE+0x14 (see optional feature).
  - All other addresses are unmapped.
- Reads:
  - MemRdData = selected word when MemRd=1, else 0.
  - Unmapped reads return 0.
  - Narrow registers are zero-extended.
  - Read is same-cycle combinational; no added latency.
- Writes:
  - Take effect at the rising edge when MemWr=1.
  - Unmapped writes are ignored.
  - MemRd and MemWr both high to the same address: MemRdData shows the old value; the new value is visible next cycle.
- Reset:
  - On rst=0, asynchronously: TH=0, TL=0, TCON=0, leds=0, digi=0, SysTick=0, irq=0.
  - RAM contents are not reset.
  - Reset asserted mid-count aborts counting immediately.
  - After release, the timer stays idle until TCON[0] is written.
- Timer:
  - TCON[0] = enable, TCON[1] = interrupt enable, TCON[2] = overflow status.
  - While TCON[0]=1, TL increments by 1 every cycle.
  - When TL==32'hFFFF_FFFF and enabled, the next edge loads TL<=TH (reload, not wrap to 0) and sets TCON[2]=1 if TCON[1]=1.
  - TCON[2] is sticky; software clears it by writing TCON.
- Simultaneous events:
  - A CPU write to TL in the same cycle as an increment or reload: the write wins.
  - A CPU write to TCON in the same cycle as overflow: the written value wins, including bit 2.
  - A write to TH during overflow: the reload uses the old TH; the new TH is used for the next reload.
- Writing TCON[0]=0 freezes TL at its current value.

Optional Feature:
- Macro SYSTICK_EN.
- Defined: SysTick is a 32-bit free-running counter.
  - Reset 0, +1 every cycle, wraps 0xFFFF_FFFF -> 0.
  - Read-only; writes are ignored.
  - Readable at IO_BASE+0x14.
- Undefined: no counter logic; IO_BASE+0x14 behaves as unmapped (reads 0).

Test Plan:
- RAM access: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 next cycle -> MemRdData=0xDEADBEEF. Load 0x0000_0013 -> same word. Load with MemRd=0 -> 0.
- Timer reload and interrupt:
  - Stimulus: TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=3'b011.
  - Expected: TL reads 0xFFFF_FFFF one cycle later, then 0xFFFF_FFF0 with TCON=3'b111 and irq=1.
  - Then write TCON=3'b011 -> irq=0 and counting continues.
- Write priority: with the timer enabled, write TL=0x0000_0005 on a counting cycle -> TL reads 5 next cycle, then 6 on the following cycle.
- Peripherals: write leds=0x5A and digi=0x8_3F -> leds=8'h5A, digi=12'h83F. Read IO_BASE+0x20 -> 0. A write there changes no state.
- Reset mid-operation: drop rst for part of a cycle while counting -> all outputs and registers go to 0 immediately without a clock edge. A previously stored RAM word is still readable after release.
- SYSTICK_EN:
  - Defined: two reads of IO_BASE+0x14 taken N cycles apart differ by N.
  - Undefined: the read returns 0.
